vx_csr_arb: RTL and testbench



---
 rtl/vx_csr_arb.sv | 168 ++++++++++++++++
 tb/tb_vx_csr_arb.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_csr_arb.sv
// CSR request router and response merger between the host CSR port and
// NUM_REQS downstream units; optional register stages on both directions.
module vx_csr_arb #(
  parameter int unsigned NUM_REQS     = 1,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned BUFFERED_REQ = 0,
  parameter int unsigned BUFFERED_RSP = 0,
  localparam int unsigned IDW         = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset,

  input  logic [IDW-1:0]                        request_id,
  input  logic                                  req_valid_in,
  input  logic [ADDR_WIDTH-1:0]                 req_addr_in,
  input  logic                                  req_rw_in,
  input  logic [DATA_WIDTH-1:0]                 req_data_in,
  output logic                                  req_ready_in,

  output logic [NUM_REQS-1:0]                   req_valid_out,
  output logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]   req_addr_out,
  output logic [NUM_REQS-1:0]                   req_rw_out,
  output logic [NUM_REQS-1:0][DATA_WIDTH-1:0]   req_data_out,
  input  logic [NUM_REQS-1:0]                   req_ready_out,

  input  logic [NUM_REQS-1:0]                   rsp_valid_in,
  input  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]   rsp_data_in,
  output logic [NUM_REQS-1:0]                   rsp_ready_in,

  output logic                                  rsp_valid_out,
  output logic [DATA_WIDTH-1:0]                 rsp_data_out,
  input  logic                                  rsp_ready_out
);

  // ---------------------------------------------------------------------
  // Request routing
  // ---------------------------------------------------------------------
  logic [IDW-1:0]      sel_id_c;
  logic [NUM_REQS-1:0] sel_c;
  logic [NUM_REQS-1:0] req_accept_c;

  // One-hot destination; an out-of-range id selects nobody and so stalls.
  always_comb begin
    sel_id_c = (NUM_REQS == 1) ? '0 : request_id;
    sel_c    = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (32'(sel_id_c) == i) sel_c[i] = 1'b1;
    end
  end

  always_comb begin
    req_ready_in = 1'b0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (sel_c[i]) req_ready_in = req_accept_c[i];
    end
  end

  if (BUFFERED_REQ != 0) begin : g_req_buf
    for (genvar i = 0; i < int'(NUM_REQS); i++) begin : g_unit
      logic                  valid_q, valid_d;
      logic [ADDR_WIDTH-1:0] addr_q;
      logic                  rw_q;
      logic [DATA_WIDTH-1:0] data_q;
      logic                  load_c;

      assign req_accept_c[i] = !valid_q || req_ready_out[i];
      assign load_c          = req_valid_in && sel_c[i] && req_accept_c[i];

      always_comb begin
        valid_d = valid_q;
        if (load_c)                valid_d = 1'b1;
        else if (req_ready_out[i]) valid_d = 1'b0;
      end

      always_ff @(posedge clk) begin
        if (reset) valid_q <= 1'b0;
        else       valid_q <= valid_d;
      end

      // Payload needs no reset; it is qualified by valid_q.
      always_ff @(posedge clk) begin
        if (load_c) begin
          addr_q <= req_addr_in;
          rw_q   <= req_rw_in;
          data_q <= req_data_in;
        end
      end

      assign req_valid_out[i] = valid_q;
      assign req_addr_out[i]  = addr_q;
      assign req_rw_out[i]    = rw_q;
      assign req_data_out[i]  = data_q;
    end
  end else begin : g_req_comb
    for (genvar i = 0; i < int'(NUM_REQS); i++) begin : g_unit
      assign req_accept_c[i]  = req_ready_out[i];
      assign req_valid_out[i] = req_valid_in && sel_c[i];
      assign req_addr_out[i]  = req_addr_in;
      assign req_rw_out[i]    = req_rw_in;
      assign req_data_out[i]  = req_data_in;
    end
  end

  // ---------------------------------------------------------------------
  // Response merging (round-robin)
  // ---------------------------------------------------------------------
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_id_c;
  logic [IDW-1:0] scan_id_c;
  logic           rsp_any_c;
  logic           dn_accept_c;
  logic           rsp_fire_c;

  // First valid unit searching from the pointer, wrapping modulo NUM_REQS.
  always_comb begin
    grant_id_c = '0;
    scan_id_c  = '0;
    rsp_any_c  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      scan_id_c = IDW'((32'(rr_ptr_q) + k) % NUM_REQS);
      if (!rsp_any_c && rsp_valid_in[scan_id_c]) begin
        rsp_any_c  = 1'b1;
        grant_id_c = scan_id_c;
      end
    end
  end

  assign rsp_fire_c = rsp_any_c && dn_accept_c;

  always_comb begin
    rsp_ready_in = '0;
    rr_ptr_d     = rr_ptr_q;
    if (rsp_fire_c) begin
      rsp_ready_in[grant_id_c] = 1'b1;
      rr_ptr_d = IDW'((32'(grant_id_c) + 32'd1) % NUM_REQS);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  if (BUFFERED_RSP != 0) begin : g_rsp_buf
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;

    assign dn_accept_c = !rsp_valid_q || rsp_ready_out;

    always_ff @(posedge clk) begin
      if (reset)            rsp_valid_q <= 1'b0;
      else if (dn_accept_c) rsp_valid_q <= rsp_any_c;
    end

    always_ff @(posedge clk) begin
      if (rsp_fire_c) rsp_data_q <= rsp_data_in[grant_id_c];
    end

    assign rsp_valid_out = rsp_valid_q;
    assign rsp_data_out  = rsp_data_q;
  end else begin : g_rsp_comb
    assign dn_accept_c   = rsp_ready_out;
    assign rsp_valid_out = rsp_any_c;
    assign rsp_data_out  = rsp_data_in[grant_id_c];
  end

endmodule

// File: tb/tb_vx_csr_arb.sv
// Directed bench for vx_csr_arb: 4-unit fully buffered, 1-unit pass-through
// and 3-unit unbuffered instances.
module tb_vx_csr_arb;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 4 units, both buffers on
  logic [1:0]        r4_id;
  logic              r4_vin, r4_rw, r4_rdy_in;
  logic [11:0]       r4_addr;
  logic [31:0]       r4_data;
  logic [3:0]        r4_vout, r4_rw_out, r4_rdy_out;
  logic [3:0][11:0]  r4_addr_out;
  logic [3:0][31:0]  r4_data_out;
  logic [3:0]        s4_vin, s4_rdy_in;
  logic [3:0][31:0]  s4_data;
  logic              s4_vout, s4_rdy_out;
  logic [31:0]       s4_dout;

  // 1 unit, unbuffered
  logic [0:0]        r1_id;
  logic              r1_vin, r1_rw, r1_rdy_in;
  logic [11:0]       r1_addr;
  logic [31:0]       r1_data;
  logic [0:0]        r1_vout, r1_rw_out, r1_rdy_out;
  logic [0:0][11:0]  r1_addr_out;
  logic [0:0][31:0]  r1_data_out;
  logic [0:0]        s1_vin, s1_rdy_in;
  logic [0:0][31:0]  s1_data;
  logic              s1_vout, s1_rdy_out;
  logic [31:0]       s1_dout;

  // 3 units, unbuffered
  logic [1:0]        r3_id;
  logic              r3_vin, r3_rw, r3_rdy_in;
  logic [11:0]       r3_addr;
  logic [31:0]       r3_data;
  logic [2:0]        r3_vout, r3_rw_out, r3_rdy_out;
  logic [2:0][11:0]  r3_addr_out;
  logic [2:0][31:0]  r3_data_out;
  logic [2:0]        s3_vin, s3_rdy_in;
  logic [2:0][31:0]  s3_data;
  logic              s3_vout, s3_rdy_out;
  logic [31:0]       s3_dout;

  vx_csr_arb #(.NUM_REQS(4), .DATA_WIDTH(32), .ADDR_WIDTH(12),
               .BUFFERED_REQ(1), .BUFFERED_RSP(1)) u4 (
    .clk(clk), .reset(reset), .request_id(r4_id),
    .req_valid_in(r4_vin), .req_addr_in(r4_addr), .req_rw_in(r4_rw),
    .req_data_in(r4_data), .req_ready_in(r4_rdy_in),
    .req_valid_out(r4_vout), .req_addr_out(r4_addr_out), .req_rw_out(r4_rw_out),
    .req_data_out(r4_data_out), .req_ready_out(r4_rdy_out),
    .rsp_valid_in(s4_vin), .rsp_data_in(s4_data), .rsp_ready_in(s4_rdy_in),
    .rsp_valid_out(s4_vout), .rsp_data_out(s4_dout), .rsp_ready_out(s4_rdy_out));

  vx_csr_arb #(.NUM_REQS(1), .DATA_WIDTH(32), .ADDR_WIDTH(12),
               .BUFFERED_REQ(0), .BUFFERED_RSP(0)) u1 (
    .clk(clk), .reset(reset), .request_id(r1_id),
    .req_valid_in(r1_vin), .req_addr_in(r1_addr), .req_rw_in(r1_rw),
    .req_data_in(r1_data), .req_ready_in(r1_rdy_in),
    .req_valid_out(r1_vout), .req_addr_out(r1_addr_out), .req_rw_out(r1_rw_out),
    .req_data_out(r1_data_out), .req_ready_out(r1_rdy_out),
    .rsp_valid_in(s1_vin), .rsp_data_in(s1_data), .rsp_ready_in(s1_rdy_in),
    .rsp_valid_out(s1_vout), .rsp_data_out(s1_dout), .rsp_ready_out(s1_rdy_out));

  vx_csr_arb #(.NUM_REQS(3), .DATA_WIDTH(32), .ADDR_WIDTH(12),
               .BUFFERED_REQ(0), .BUFFERED_RSP(0)) u3 (
    .clk(clk), .reset(reset), .request_id(r3_id),
    .req_valid_in(r3_vin), .req_addr_in(r3_addr), .req_rw_in(r3_rw),
    .req_data_in(r3_data), .req_ready_in(r3_rdy_in),
    .req_valid_out(r3_vout), .req_addr_out(r3_addr_out), .req_rw_out(r3_rw_out),
    .req_data_out(r3_data_out), .req_ready_out(r3_rdy_out),
    .rsp_valid_in(s3_vin), .rsp_data_in(s3_data), .rsp_ready_in(s3_rdy_in),
    .rsp_valid_out(s3_vout), .rsp_data_out(s3_dout), .rsp_ready_out(s3_rdy_out));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    r4_rdy_out = 4'hF;
    #1;
    checks++; if (r4_vout !== 4'b0000) begin errors++; $display("FAIL reset_req_valid: got %b expected 0000", r4_vout); end
    checks++; if (s4_vout !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", s4_vout); end
    for (int id = 0; id < 4; id++) begin
      r4_id = 2'(id);
      #1;
      checks++; if (r4_rdy_in !== 1'b1) begin errors++; $display("FAIL reset_ready_id%0d: got %b expected 1", id, r4_rdy_in); end
    end
    checks++; if (r1_vout !== 1'b0) begin errors++; $display("FAIL reset_n1_req_valid: got %b expected 0", r1_vout); end
    checks++; if (s1_vout !== 1'b0) begin errors++; $display("FAIL reset_n1_rsp_valid: got %b expected 0", s1_vout); end
  endtask

  task automatic test_routing();
    tick();
    r4_rdy_out = 4'hF;
    r4_id = 2'd2; r4_addr = 12'hCC0; r4_rw = 1'b0; r4_data = 32'h0; r4_vin = 1'b1;
    #1;
    checks++; if (r4_rdy_in !== 1'b1) begin errors++; $display("FAIL route_ready: got %b expected 1", r4_rdy_in); end
    tick();
    r4_vin = 1'b0;
    #1;
    checks++; if (r4_vout !== 4'b0100) begin errors++; $display("FAIL route_valid: got %b expected 0100", r4_vout); end
    checks++; if (r4_addr_out[2] !== 12'hCC0) begin errors++; $display("FAIL route_addr: got %h expected cc0", r4_addr_out[2]); end
    checks++; if (r4_data_out[2] !== 32'h0) begin errors++; $display("FAIL route_data: got %h expected 0", r4_data_out[2]); end
    tick();
    checks++; if (r4_vout !== 4'b0000) begin errors++; $display("FAIL route_drain: got %b expected 0000", r4_vout); end
    r4_id = 2'd0; r4_addr = 12'h123; r4_rw = 1'b1; r4_data = 32'hDEADBEEF; r4_vin = 1'b1;
    tick();
    r4_vin = 1'b0;
    #1;
    checks++; if (r4_vout !== 4'b0001) begin errors++; $display("FAIL route0_valid: got %b expected 0001", r4_vout); end
    checks++; if (r4_rw_out[0] !== 1'b1) begin errors++; $display("FAIL route0_rw: got %b expected 1", r4_rw_out[0]); end
    checks++; if (r4_addr_out[0] !== 12'h123) begin errors++; $display("FAIL route0_addr: got %h expected 123", r4_addr_out[0]); end
    checks++; if (r4_data_out[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL route0_data: got %h expected deadbeef", r4_data_out[0]); end
    tick();
  endtask

  task automatic test_back_pressure();
    r4_rdy_out = 4'b1101;
    r4_id = 2'd1; r4_addr = 12'h101; r4_rw = 1'b1; r4_data = 32'h11; r4_vin = 1'b1;
    #1;
    checks++; if (r4_rdy_in !== 1'b1) begin errors++; $display("FAIL bp_first_ready: got %b expected 1", r4_rdy_in); end
    tick();
    r4_addr = 12'h102; r4_rw = 1'b0; r4_data = 32'h22;
    #1;
    checks++; if (r4_rdy_in !== 1'b0) begin errors++; $display("FAIL bp_second_stall: got %b expected 0", r4_rdy_in); end
    checks++; if (r4_vout !== 4'b0010) begin errors++; $display("FAIL bp_held_valid: got %b expected 0010", r4_vout); end
    checks++; if (r4_addr_out[1] !== 12'h101) begin errors++; $display("FAIL bp_held_addr: got %h expected 101", r4_addr_out[1]); end
    tick();
    checks++; if (r4_rdy_in !== 1'b0) begin errors++; $display("FAIL bp_still_stall: got %b expected 0", r4_rdy_in); end
    checks++; if (r4_data_out[1] !== 32'h11) begin errors++; $display("FAIL bp_held_data: got %h expected 11", r4_data_out[1]); end
    r4_rdy_out = 4'hF;
    #1;
    checks++; if (r4_rdy_in !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", r4_rdy_in); end
    tick();
    r4_vin = 1'b0;
    #1;
    checks++; if (r4_vout !== 4'b0010) begin errors++; $display("FAIL bp_second_valid: got %b expected 0010", r4_vout); end
    checks++; if (r4_addr_out[1] !== 12'h102) begin errors++; $display("FAIL bp_second_addr: got %h expected 102", r4_addr_out[1]); end
    checks++; if (r4_data_out[1] !== 32'h22) begin errors++; $display("FAIL bp_second_data: got %h expected 22", r4_data_out[1]); end
    checks++; if (r4_rw_out[1] !== 1'b0) begin errors++; $display("FAIL bp_second_rw: got %b expected 0", r4_rw_out[1]); end
    tick();
    checks++; if (r4_vout !== 4'b0000) begin errors++; $display("FAIL bp_drain: got %b expected 0000", r4_vout); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [3];
    d[0] = 32'h30; d[1] = 32'h31; d[2] = 32'h32;
    r4_rdy_out = 4'hF;
    r4_id = 2'd3; r4_rw = 1'b0; r4_vin = 1'b1;
    r4_data = d[0]; r4_addr = 12'h300;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k < 2) begin
        r4_data = d[k+1]; r4_addr = 12'(12'h301 + k);
      end else begin
        r4_vin = 1'b0;
      end
      #1;
      checks++; if (r4_vout !== 4'b1000) begin errors++; $display("FAIL b2b_valid%0d: got %b expected 1000", k, r4_vout); end
      checks++; if (r4_data_out[3] !== d[k]) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", k, r4_data_out[3], d[k]); end
      checks++; if (r4_rdy_in !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b expected 1", k, r4_rdy_in); end
    end
    tick();
    checks++; if (r4_vout !== 4'b0000) begin errors++; $display("FAIL b2b_drain: got %b expected 0000", r4_vout); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_d [5];
    logic [3:0]  exp_r [5];
    exp_d[0] = 32'hA0; exp_d[1] = 32'hA1; exp_d[2] = 32'hA2; exp_d[3] = 32'hA3; exp_d[4] = 32'hA0;
    exp_r[0] = 4'b0010; exp_r[1] = 4'b0100; exp_r[2] = 4'b1000; exp_r[3] = 4'b0001; exp_r[4] = 4'b0010;
    s4_data[0] = 32'hA0; s4_data[1] = 32'hA1; s4_data[2] = 32'hA2; s4_data[3] = 32'hA3;
    s4_vin = 4'hF; s4_rdy_out = 1'b1;
    #1;
    checks++; if (s4_rdy_in !== 4'b0001) begin errors++; $display("FAIL rr_first_grant: got %b expected 0001", s4_rdy_in); end
    checks++; if (s4_vout !== 1'b0) begin errors++; $display("FAIL rr_latency: got %b expected 0", s4_vout); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (s4_vout !== 1'b1) begin errors++; $display("FAIL rr_valid%0d: got %b expected 1", k, s4_vout); end
      checks++; if (s4_dout !== exp_d[k]) begin errors++; $display("FAIL rr_data%0d: got %h expected %h", k, s4_dout, exp_d[k]); end
      checks++; if (s4_rdy_in !== exp_r[k]) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, s4_rdy_in, exp_r[k]); end
    end
    s4_vin = 4'b0000;
    tick();
    checks++; if (s4_vout !== 1'b0) begin errors++; $display("FAIL rr_drain: got %b expected 0", s4_vout); end
  endtask

  task automatic test_rsp_stall();
    s4_vin = 4'b1000; s4_data[3] = 32'h1234; s4_rdy_out = 1'b0;
    #1;
    checks++; if (s4_rdy_in !== 4'b1000) begin errors++; $display("FAIL stall_accept_empty: got %b expected 1000", s4_rdy_in); end
    tick();
    s4_data[3] = 32'h5678;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (s4_vout !== 1'b1) begin errors++; $display("FAIL stall_valid%0d: got %b expected 1", k, s4_vout); end
      checks++; if (s4_dout !== 32'h1234) begin errors++; $display("FAIL stall_data%0d: got %h expected 1234", k, s4_dout); end
      checks++; if (s4_rdy_in !== 4'b0000) begin errors++; $display("FAIL stall_ready%0d: got %b expected 0000", k, s4_rdy_in); end
      tick();
    end
    s4_rdy_out = 1'b1;
    #1;
    checks++; if (s4_rdy_in !== 4'b1000) begin errors++; $display("FAIL stall_release: got %b expected 1000", s4_rdy_in); end
    tick();
    s4_vin = 4'b0000;
    #1;
    checks++; if (s4_vout !== 1'b1) begin errors++; $display("FAIL stall_next_valid: got %b expected 1", s4_vout); end
    checks++; if (s4_dout !== 32'h5678) begin errors++; $display("FAIL stall_next_data: got %h expected 5678", s4_dout); end
    tick();
    checks++; if (s4_vout !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b expected 0", s4_vout); end
  endtask

  task automatic test_single_unit();
    r1_id = 1'b1; r1_vin = 1'b1; r1_addr = 12'h3A5; r1_rw = 1'b1; r1_data = 32'h0BADF00D; r1_rdy_out = 1'b0;
    #1;
    checks++; if (r1_vout !== 1'b1) begin errors++; $display("FAIL n1_valid: got %b expected 1", r1_vout); end
    checks++; if (r1_rdy_in !== 1'b0) begin errors++; $display("FAIL n1_ready_low: got %b expected 0", r1_rdy_in); end
    checks++; if (r1_addr_out[0] !== 12'h3A5) begin errors++; $display("FAIL n1_addr: got %h expected 3a5", r1_addr_out[0]); end
    checks++; if (r1_data_out[0] !== 32'h0BADF00D) begin errors++; $display("FAIL n1_data: got %h expected 0badf00d", r1_data_out[0]); end
    r1_rdy_out = 1'b1;
    #1;
    checks++; if (r1_rdy_in !== 1'b1) begin errors++; $display("FAIL n1_ready_high: got %b expected 1", r1_rdy_in); end
    r1_vin = 1'b0;
    #1;
    checks++; if (r1_vout !== 1'b0) begin errors++; $display("FAIL n1_valid_drop: got %b expected 0", r1_vout); end
    s1_vin = 1'b1; s1_data[0] = 32'hCAFE; s1_rdy_out = 1'b0;
    #1;
    checks++; if (s1_vout !== 1'b1) begin errors++; $display("FAIL n1_rsp_valid: got %b expected 1", s1_vout); end
    checks++; if (s1_dout !== 32'hCAFE) begin errors++; $display("FAIL n1_rsp_data: got %h expected cafe", s1_dout); end
    checks++; if (s1_rdy_in !== 1'b0) begin errors++; $display("FAIL n1_rsp_ready_low: got %b expected 0", s1_rdy_in); end
    s1_rdy_out = 1'b1;
    #1;
    checks++; if (s1_rdy_in !== 1'b1) begin errors++; $display("FAIL n1_rsp_ready_high: got %b expected 1", s1_rdy_in); end
    s1_vin = 1'b0;
    #1;
    checks++; if (s1_vout !== 1'b0) begin errors++; $display("FAIL n1_rsp_drop: got %b expected 0", s1_vout); end
  endtask

  task automatic test_bad_id();
    r3_rdy_out = 3'b111; r3_vin = 1'b1; r3_id = 2'd3;
    r3_addr = 12'h0AB; r3_rw = 1'b0; r3_data = 32'h77;
    #1;
    checks++; if (r3_vout !== 3'b000) begin errors++; $display("FAIL badid_valid: got %b expected 000", r3_vout); end
    checks++; if (r3_rdy_in !== 1'b0) begin errors++; $display("FAIL badid_ready: got %b expected 0", r3_rdy_in); end
    r3_id = 2'd2;
    #1;
    checks++; if (r3_vout !== 3'b100) begin errors++; $display("FAIL id2_valid: got %b expected 100", r3_vout); end
    checks++; if (r3_rdy_in !== 1'b1) begin errors++; $display("FAIL id2_ready: got %b expected 1", r3_rdy_in); end
    r3_rdy_out = 3'b011;
    #1;
    checks++; if (r3_vout !== 3'b100) begin errors++; $display("FAIL id2_valid_no_ready: got %b expected 100", r3_vout); end
    checks++; if (r3_rdy_in !== 1'b0) begin errors++; $display("FAIL id2_ready_low: got %b expected 0", r3_rdy_in); end
    r3_vin = 1'b0;
  endtask

  task automatic test_round_robin_n3();
    logic [2:0]  v   [10];
    logic        r   [10];
    logic [31:0] d   [10];
    logic [2:0]  rin [10];
    v[0]=3'b111; r[0]=1; d[0]=32'hB0; rin[0]=3'b001;
    v[1]=3'b111; r[1]=1; d[1]=32'hB1; rin[1]=3'b010;
    v[2]=3'b111; r[2]=1; d[2]=32'hB2; rin[2]=3'b100;
    v[3]=3'b111; r[3]=1; d[3]=32'hB0; rin[3]=3'b001;
    v[4]=3'b111; r[4]=0; d[4]=32'hB1; rin[4]=3'b000;
    v[5]=3'b011; r[5]=1; d[5]=32'hB1; rin[5]=3'b010;
    v[6]=3'b011; r[6]=1; d[6]=32'hB0; rin[6]=3'b001;
    v[7]=3'b101; r[7]=1; d[7]=32'hB2; rin[7]=3'b100;
    v[8]=3'b101; r[8]=1; d[8]=32'hB0; rin[8]=3'b001;
    v[9]=3'b000; r[9]=1; d[9]=32'h0;  rin[9]=3'b000;
    s3_data[0] = 32'hB0; s3_data[1] = 32'hB1; s3_data[2] = 32'hB2;
    tick();
    for (int k = 0; k < 10; k++) begin
      s3_vin = v[k]; s3_rdy_out = r[k];
      #1;
      checks++; if (s3_vout !== (v[k] != 3'b000)) begin errors++; $display("FAIL rr3_valid%0d: got %b expected %b", k, s3_vout, (v[k] != 3'b000)); end
      if (v[k] != 3'b000) begin
        checks++; if (s3_dout !== d[k]) begin errors++; $display("FAIL rr3_data%0d: got %h expected %h", k, s3_dout, d[k]); end
      end
      checks++; if (s3_rdy_in !== rin[k]) begin errors++; $display("FAIL rr3_grant%0d: got %b expected %b", k, s3_rdy_in, rin[k]); end
      tick();
    end
  endtask

  task automatic test_reset_discard();
    r4_id = 2'd0; r4_vin = 1'b1; r4_addr = 12'h0EE; r4_data = 32'h99; r4_rw = 1'b0; r4_rdy_out = 4'b0000;
    s4_vin = 4'b0001; s4_data[0] = 32'h55; s4_rdy_out = 1'b0;
    tick();
    r4_vin = 1'b0; s4_vin = 4'b0000;
    #1;
    checks++; if (r4_vout !== 4'b0001) begin errors++; $display("FAIL rst_pre_req: got %b expected 0001", r4_vout); end
    checks++; if (s4_vout !== 1'b1) begin errors++; $display("FAIL rst_pre_rsp: got %b expected 1", s4_vout); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (r4_vout !== 4'b0000) begin errors++; $display("FAIL rst_discard_req: got %b expected 0000", r4_vout); end
    checks++; if (s4_vout !== 1'b0) begin errors++; $display("FAIL rst_discard_rsp: got %b expected 0", s4_vout); end
    checks++; if (r4_rdy_in !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", r4_rdy_in); end
    tick();
    checks++; if (r4_vout !== 4'b0000) begin errors++; $display("FAIL rst_no_replay: got %b expected 0000", r4_vout); end
    r4_rdy_out = 4'hF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    r4_id = '0; r4_vin = 1'b0; r4_addr = '0; r4_rw = 1'b0; r4_data = '0; r4_rdy_out = '0;
    s4_vin = '0; s4_data = '0; s4_rdy_out = 1'b0;
    r1_id = '0; r1_vin = 1'b0; r1_addr = '0; r1_rw = 1'b0; r1_data = '0; r1_rdy_out = '0;
    s1_vin = '0; s1_data = '0; s1_rdy_out = 1'b0;
    r3_id = '0; r3_vin = 1'b0; r3_addr = '0; r3_rw = 1'b0; r3_data = '0; r3_rdy_out = '0;
    s3_vin = '0; s3_data = '0; s3_rdy_out = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    test_reset();
    test_routing();
    test_back_pressure();
    test_back_to_back();
    test_round_robin();
    test_rsp_stall();
    test_single_unit();
    test_bad_id();
    test_round_robin_n3();
    test_reset_discard();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
